uart_transceiver: RTL and testbench

Self-contained 8N1 UART: a 16x-oversampling baud tick generator, a transmitter and a receiver sharing one clock and one tick. The transmitter serialises a byte on tx. The receiver deserialises rx and strobes rx_done. It sits between a byte-level host interface and the external serial pins; benches loop tx back to rx.

---
 rtl/uart_transceiver.sv | 173 +++++++++++++++++
 tb/tb_uart_transceiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// 8N1 UART: 16x-oversampling baud tick, transmitter and receiver sharing one clock.
// TX and RX are independent; rx passes through a two-flop synchroniser before use.
module uart_transceiver #(
  parameter int CLOCK_FREQ = 1_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       tick
);

  localparam int DIV_CALC = (CLOCK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
  localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [CW-1:0] baud_cnt;

  logic [1:0] tx_state;
  logic [3:0] tx_ticks;
  logic [2:0] tx_bits;
  logic [7:0] tx_shift;

  logic       rx_meta;
  logic       rx_sync;
  logic [1:0] rx_state;
  logic [3:0] rx_ticks;
  logic [2:0] rx_bits;
  logic [7:0] rx_shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_cnt <= '0;
      tick     <= 1'b0;
    end else if (baud_cnt == DIV_LAST) begin
      baud_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
      tick     <= 1'b0;
    end
  end

  // tx is driven from the next bit of tx_shift as each bit period closes, so
  // every bit after the start bit spans exactly 16 ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_ticks <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            tx_shift <= tx_data;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_ticks <= '0;
            tx_state <= S_START;
          end
        end
        S_START: if (tick) begin
          tx_ticks <= tx_ticks + 4'd1;
          if (tx_ticks == 4'd15) begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bits  <= '0;
            tx_state <= S_DATA;
          end
        end
        S_DATA: if (tick) begin
          tx_ticks <= tx_ticks + 4'd1;
          if (tx_ticks == 4'd15) begin
            if (tx_bits == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bits  <= tx_bits + 3'd1;
            end
          end
        end
        default: if (tick) begin
          tx_ticks <= tx_ticks + 4'd1;
          if (tx_ticks == 4'd15) begin
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state     <= S_IDLE;
      rx_ticks     <= '0;
      rx_bits      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        S_IDLE: if (tick && !rx_sync) begin
          rx_ticks <= '0;
          rx_state <= S_START;
        end
        S_START: if (tick) begin
          if (rx_ticks == 4'd7) begin
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_ticks <= rx_ticks + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          rx_ticks <= rx_ticks + 4'd1;
          if (rx_ticks == 4'd15) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) rx_state <= S_STOP;
          end
        end
        default: if (tick) begin
          rx_ticks <= rx_ticks + 4'd1;
          if (rx_ticks == 4'd15) begin
            if (rx_sync) begin
              rx_data <= rx_shift;
              rx_done <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
            rx_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Loopback bench for uart_transceiver: random bytes, waveform model of the 8N1 frame,
// glitch, framing-error and mid-frame reset scenarios.
module tb_uart_transceiver;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 9600;
  localparam int TB_DIV     = (CLOCK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int BIT_CYC    = 16 * TB_DIV;
  localparam int WAVE_MAX   = 1300;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       tick;

  logic loop_en;
  logic rx_drv;
  assign rx_line = loop_en ? tx : rx_drv;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  int unsigned ferr_cnt = 0;
  logic [7:0] exp_last;

  uart_transceiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .rx(rx_line), .rx_data(rx_data),
    .rx_done(rx_done), .rx_frame_err(rx_frame_err), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) done_cnt++;
    if (rx_frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends b over the looped-back line and compares tx cycle by cycle with the ideal
  // 8N1 frame; returns on the first cycle tx_busy is seen low.
  task automatic send_frame(input logic [7:0] b, input bit poke);
    logic [9:0]  bits;
    logic        wave [0:WAVE_MAX-1];
    logic        expv;
    int unsigned busy_len, s_len, bad, done0, ferr0, done_at;
    bits = {1'b1, b, 1'b0};
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    done_at = 0;
    busy_len = 0;
    tx_data = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int unsigned i = 0; i < WAVE_MAX; i++) begin
      wave[i] = tx;
      if (rx_done && done_at == 0) done_at = i;
      if (!tx_busy) begin
        busy_len = i;
        break;
      end
      if (i == 2) tx_data = ~b;
      if (poke && i == 300) begin
        tx_data = 8'h3C;
        tx_start = 1'b1;
      end
      if (poke && i == 301) tx_start = 1'b0;
      @(negedge clk);
    end
    check("busy_len_in_range",
          32'(busy_len > 9 * BIT_CYC + 15 * TB_DIV && busy_len <= 10 * BIT_CYC), 32'd1);
    s_len = (busy_len >= 9 * BIT_CYC) ? busy_len - 9 * BIT_CYC : 0;
    bad = 0;
    for (int unsigned i = 0; i < busy_len; i++) begin
      expv = (i < s_len) ? 1'b0 : bits[(i - s_len) / BIT_CYC + 1];
      if (wave[i] !== expv) bad++;
    end
    check("tx_wave_bad_cycles", bad, 0);
    check("tx_idle_after_frame", 32'(tx), 32'd1);
    check("rx_done_pulses", done_cnt - done0, 1);
    check("rx_ferr_pulses", ferr_cnt - ferr0, 0);
    check("rx_data_loopback", 32'(rx_data), 32'(b));
    check("rx_done_latency_in_range",
          32'(done_at >= 3 + 9 * BIT_CYC + 8 * TB_DIV &&
              done_at <= 3 + 9 * BIT_CYC + 8 * TB_DIV + TB_DIV - 1), 32'd1);
    exp_last = b;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int unsigned k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int unsigned n_ticks, last_tick, bad_int, d0, f0, gap;
    logic [7:0] rb;
    rst = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    rx_drv = 1'b1;
    loop_en = 1'b1;
    exp_last = 8'h00;

    repeat (2) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_rx_done", 32'(rx_done), 32'd0);
    check("reset_rx_ferr", 32'(rx_frame_err), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_tick", 32'(tick), 32'd0);

    rst = 1'b1;
    n_ticks = 0;
    last_tick = 0;
    bad_int = 0;
    for (int unsigned i = 1; i <= 10 * TB_DIV; i++) begin
      @(negedge clk);
      if (tick) begin
        if (n_ticks > 0 && i - last_tick != TB_DIV) bad_int++;
        n_ticks++;
        last_tick = i;
      end
    end
    check("tick_count", n_ticks, 10);
    check("tick_bad_intervals", bad_int, 0);

    send_frame(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'hA5, 1'b1);
    check("no_frame_after_ignored_start", 32'(tx_busy), 32'd0);

    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);

    for (int unsigned k = 0; k < 4; k++) begin
      gap = $urandom_range(0, 30);
      repeat (gap) @(negedge clk);
      rb = 8'($urandom);
      send_frame(rb, k == 1);
    end

    loop_en = 1'b0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (3 * TB_DIV) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_rx_data_kept", 32'(rx_data), 32'(exp_last));
    loop_en = 1'b1;
    send_frame(8'h5A, 1'b0);

    loop_en = 1'b0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    drive_rx(8'h81, 1'b0);
    repeat (200) @(negedge clk);
    check("ferr_pulse_count", ferr_cnt - f0, 1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_rx_data_kept", 32'(rx_data), 32'(exp_last));

    rb = 8'($urandom);
    repeat ($urandom_range(0, 20)) @(negedge clk);
    d0 = done_cnt;
    f0 = ferr_cnt;
    drive_rx(rb, 1'b1);
    repeat (50) @(negedge clk);
    check("pin_frame_done", done_cnt - d0, 1);
    check("pin_frame_no_ferr", ferr_cnt - f0, 0);
    check("pin_frame_data", 32'(rx_data), 32'(rb));
    exp_last = rb;

    loop_en = 1'b1;
    d0 = done_cnt;
    f0 = ferr_cnt;
    tx_data = 8'($urandom);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (500) @(negedge clk);
    check("midframe_busy_before_reset", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_tx", 32'(tx), 32'd1);
    check("midframe_reset_busy", 32'(tx_busy), 32'd0);
    check("midframe_reset_tick", 32'(tick), 32'd0);
    check("midframe_reset_rx_data", 32'(rx_data), 32'h00);
    rst = 1'b1;
    repeat (1500) @(negedge clk);
    check("midframe_no_done", done_cnt - d0, 0);
    check("midframe_no_ferr", ferr_cnt - f0, 0);
    check("midframe_tx_idle", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
